// File: rtl/sincronizador_vga_param.sv
// ---------------------------------------------------------------------------
// sincronizador_vga_param
//
// Parametrised VGA timing generator. A clock divider produces a one-CLK pixel
// strobe; on each strobe the horizontal/vertical counters advance and wrap
// at the configured line/frame totals. The counters are decoded into a
// visible-area flag and horizontal/vertical sync levels, and those three
// signals pass through an optional delay line. The delay line lets the sync
// and blanking outputs line up with the latency of downstream pixel-fetch
// logic. ENABLE=0 freezes the timing and blanks the display.
//
// Ports:
//   CLK           system clock, all logic on the rising edge
//   RESET         synchronous, active-high reset
//   ENABLE        1 = run, 0 = hold counters and blank the outputs
//   p_tick        one-CLK pixel strobe
//   pixel_X       horizontal counter (not delayed)
//   pixel_Y       vertical counter (not delayed)
//   video_on      pixel inside the visible area (delayed SYNC_DLY CLKs)
//   sincro_horiz  horizontal sync (delayed SYNC_DLY CLKs)
//   sincro_vert   vertical sync (delayed SYNC_DLY CLKs)
//   line_start    one-CLK strobe as pixel_X wraps to 0
//   frame_start   one-CLK strobe as both counters wrap to (0,0)
// ---------------------------------------------------------------------------
module sincronizador_vga_param #(
    parameter int DIV      = 2,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int SYNC_DLY = 0,
    parameter int CW       = 10
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          ENABLE,
    output logic          p_tick,
    output logic [CW-1:0] pixel_X,
    output logic [CW-1:0] pixel_Y,
    output logic          video_on,
    output logic          sincro_horiz,
    output logic          sincro_vert,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // A one-bit divider is kept even for DIV=1; it simply stays at 0.
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
    localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_VIS + V_FP + V_SYNC - 1);

    localparam logic H_ACT = (H_POL != 0) ? 1'b1 : 1'b0;
    localparam logic V_ACT = (V_POL != 0) ? 1'b1 : 1'b0;

    // Idle word for the delay line: blanked, both syncs at their inactive level.
    localparam logic [2:0] IDLE_WORD = {1'b0, !H_ACT, !V_ACT};

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] pixel_x_q, pixel_x_d;
    logic [CW-1:0] pixel_y_q, pixel_y_d;

    logic tick;
    logic x_last;
    logic y_last;
    logic vis_raw;
    logic hs_raw;
    logic vs_raw;

    assign tick   = ENABLE && (div_cnt_q == DIV_LAST);
    assign x_last = (pixel_x_q == H_LAST);
    assign y_last = (pixel_y_q == V_LAST);

    // Next-state for the divider and pixel counters. Everything holds while
    // ENABLE is low, so resuming continues from exactly where timing stopped.
    always_comb begin
        div_cnt_d = div_cnt_q;
        pixel_x_d = pixel_x_q;
        pixel_y_d = pixel_y_q;
        if (ENABLE) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
        end
        if (tick) begin
            if (x_last) begin
                pixel_x_d = '0;
                pixel_y_d = y_last ? '0 : pixel_y_q + CW'(1);
            end else begin
                pixel_x_d = pixel_x_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt_q <= '0;
            pixel_x_q <= '0;
            pixel_y_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pixel_x_q <= pixel_x_d;
            pixel_y_q <= pixel_y_d;
        end
    end

    // Undelayed decode. Holding (ENABLE=0) blanks the picture and parks both
    // syncs at their inactive level before they enter the delay line.
    always_comb begin
        vis_raw = ENABLE && (pixel_x_q < H_VIS_C) && (pixel_y_q < V_VIS_C);
        hs_raw  = !H_ACT;
        vs_raw  = !V_ACT;
        if (ENABLE && (pixel_x_q >= HS_FIRST) && (pixel_x_q <= HS_LAST)) begin
            hs_raw = H_ACT;
        end
        if (ENABLE && (pixel_y_q >= VS_FIRST) && (pixel_y_q <= VS_LAST)) begin
            vs_raw = V_ACT;
        end
    end

    assign p_tick      = tick;
    assign pixel_X     = pixel_x_q;
    assign pixel_Y     = pixel_y_q;
    assign line_start  = tick && x_last;
    assign frame_start = tick && x_last && y_last;

    generate
        if (SYNC_DLY == 0) begin : g_no_dly
            assign video_on     = vis_raw;
            assign sincro_horiz = hs_raw;
            assign sincro_vert  = vs_raw;
        end else begin : g_dly
            logic [2:0] dly_q [SYNC_DLY];
            logic [2:0] dly_d [SYNC_DLY];

            // Stage 0 takes the fresh decode; each later stage copies the one
            // before it, so the last stage is the decode from SYNC_DLY CLKs ago.
            always_comb begin
                dly_d[0] = {vis_raw, hs_raw, vs_raw};
                for (int i = 1; i < SYNC_DLY; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    for (int i = 0; i < SYNC_DLY; i++) begin
                        dly_q[i] <= IDLE_WORD;
                    end
                end else begin
                    for (int i = 0; i < SYNC_DLY; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign video_on     = dly_q[SYNC_DLY-1][2];
            assign sincro_horiz = dly_q[SYNC_DLY-1][1];
            assign sincro_vert  = dly_q[SYNC_DLY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_sincronizador_vga_param.sv
// ---------------------------------------------------------------------------
// tb_sincronizador_vga_param
//
// Drives two small configurations of the timing generator from one shared
// stimulus: A is DIV=1 / no delay / active-high syncs, B is DIV=2 / three-CLK
// delay / active-high hsync and active-low vsync. The reference model tracks
// only the number of enabled CLKs since reset. Counters, strobes and decode
// are derived from that number by division and modulo. The delayed outputs
// come from a short history of past decodes.
// ---------------------------------------------------------------------------
module tb_sincronizador_vga_param;

    localparam int CW = 10;

    logic CLK    = 1'b0;
    logic RESET  = 1'b1;
    logic ENABLE = 1'b0;

    // 20 ns clock period.
    always #10 CLK = ~CLK;

    logic          tickA, vidA, hsA, vsA, lsA, fsA;
    logic [CW-1:0] xA, yA;
    logic          tickB, vidB, hsB, vsB, lsB, fsB;
    logic [CW-1:0] xB, yB;

    sincronizador_vga_param #(
        .DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .SYNC_DLY(0), .CW(CW)
    ) dut_a (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
        .p_tick(tickA), .pixel_X(xA), .pixel_Y(yA),
        .video_on(vidA), .sincro_horiz(hsA), .sincro_vert(vsA),
        .line_start(lsA), .frame_start(fsA)
    );

    sincronizador_vga_param #(
        .DIV(2), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(0), .SYNC_DLY(3), .CW(CW)
    ) dut_b (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
        .p_tick(tickB), .pixel_X(xB), .pixel_Y(yB),
        .video_on(vidB), .sincro_horiz(hsB), .sincro_vert(vsB),
        .line_start(lsB), .frame_start(fsB)
    );

    // Configuration of each instance as seen by the model.
    int cDiv  [2] = '{1, 2};
    int cHVis [2] = '{4, 4};
    int cHFp  [2] = '{1, 1};
    int cHSync[2] = '{2, 2};
    int cHBp  [2] = '{1, 1};
    int cVVis [2] = '{3, 3};
    int cVFp  [2] = '{1, 1};
    int cVSync[2] = '{1, 1};
    int cVBp  [2] = '{1, 1};
    int cHPol [2] = '{1, 1};
    int cVPol [2] = '{1, 0};
    int cDly  [2] = '{0, 3};

    int checks   = 0;
    int failures = 0;

    bit          modelValid = 1'b0;
    int unsigned enCount [2];
    logic [2:0]  hist [2][8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en);
        @(posedge CLK);
        #1;
        RESET  = rst;
        ENABLE = en;
    endtask

    // Decode of the position reached after 'e' enabled CLKs: {vis, hsync, vsync}.
    function automatic logic [2:0] rawDecode(input int d, input int unsigned e, input bit en);
        int ht, vt, n, x, y;
        bit vis, hsa, vsa;
        ht  = cHVis[d] + cHFp[d] + cHSync[d] + cHBp[d];
        vt  = cVVis[d] + cVFp[d] + cVSync[d] + cVBp[d];
        n   = int'(e) / cDiv[d];
        x   = n % ht;
        y   = (n / ht) % vt;
        vis = en && (x < cHVis[d]) && (y < cVVis[d]);
        hsa = en && (x >= cHVis[d] + cHFp[d]) && (x < cHVis[d] + cHFp[d] + cHSync[d]);
        vsa = en && (y >= cVVis[d] + cVFp[d]) && (y < cVVis[d] + cVFp[d] + cVSync[d]);
        return {vis, hsa ? cHPol[d][0] : !cHPol[d][0], vsa ? cVPol[d][0] : !cVPol[d][0]};
    endfunction

    task automatic modelOutputs(input int d, input bit en,
                                output int x, output int y,
                                output bit tick, output bit ls, output bit fs,
                                output logic [2:0] dec);
        int ht, vt, n;
        ht   = cHVis[d] + cHFp[d] + cHSync[d] + cHBp[d];
        vt   = cVVis[d] + cVFp[d] + cVSync[d] + cVBp[d];
        n    = int'(enCount[d]) / cDiv[d];
        x    = n % ht;
        y    = (n / ht) % vt;
        tick = en && ((int'(enCount[d]) % cDiv[d]) == cDiv[d] - 1);
        ls   = tick && (x == ht - 1);
        fs   = ls && (y == vt - 1);
        dec  = (cDly[d] == 0) ? rawDecode(d, enCount[d], en) : hist[d][cDly[d]-1];
    endtask

    // Model state advances on the same edge the DUT samples its inputs.
    always @(posedge CLK) begin
        if (RESET) begin
            modelValid = 1'b1;
            for (int d = 0; d < 2; d++) begin
                enCount[d] = 0;
                for (int k = 0; k < 8; k++) begin
                    hist[d][k] = {1'b0, !cHPol[d][0], !cVPol[d][0]};
                end
            end
        end else if (modelValid) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 7; k > 0; k--) begin
                    hist[d][k] = hist[d][k-1];
                end
                hist[d][0] = rawDecode(d, enCount[d], ENABLE);
                if (ENABLE) begin
                    enCount[d] = enCount[d] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        int ex, ey;
        bit et, els, efs;
        logic [2:0] ed;
        if (modelValid) begin
            modelOutputs(0, ENABLE, ex, ey, et, els, efs, ed);
            checkOutput("A.pixel_X", 32'(xA), ex);
            checkOutput("A.pixel_Y", 32'(yA), ey);
            checkOutput("A.p_tick", 32'(tickA), 32'(et));
            checkOutput("A.line_start", 32'(lsA), 32'(els));
            checkOutput("A.frame_start", 32'(fsA), 32'(efs));
            checkOutput("A.video_on", 32'(vidA), 32'(ed[2]));
            checkOutput("A.sincro_horiz", 32'(hsA), 32'(ed[1]));
            checkOutput("A.sincro_vert", 32'(vsA), 32'(ed[0]));
            modelOutputs(1, ENABLE, ex, ey, et, els, efs, ed);
            checkOutput("B.pixel_X", 32'(xB), ex);
            checkOutput("B.pixel_Y", 32'(yB), ey);
            checkOutput("B.p_tick", 32'(tickB), 32'(et));
            checkOutput("B.line_start", 32'(lsB), 32'(els));
            checkOutput("B.frame_start", 32'(fsB), 32'(efs));
            checkOutput("B.video_on", 32'(vidB), 32'(ed[2]));
            checkOutput("B.sincro_horiz", 32'(hsB), 32'(ed[1]));
            checkOutput("B.sincro_vert", 32'(vsB), 32'(ed[0]));
        end
    end

    // Directed sequence with hand-computed literal expectations.
    initial begin
        int lsCntA, fsCntA, lsCntB, fsCntB;
        lsCntA = 0;
        fsCntA = 0;
        lsCntB = 0;
        fsCntB = 0;

        // Reset held with ENABLE low: counters at zero, outputs idle.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst.A.pixel_X", 32'(xA), 0);
        checkOutput("rst.A.p_tick", 32'(tickA), 0);
        checkOutput("rst.A.video_on", 32'(vidA), 0);
        checkOutput("rst.A.sincro_horiz", 32'(hsA), 0);
        checkOutput("rst.A.sincro_vert", 32'(vsA), 0);
        checkOutput("rst.B.sincro_horiz", 32'(hsB), 0);
        checkOutput("rst.B.sincro_vert", 32'(vsB), 1);
        checkOutput("rst.B.video_on", 32'(vidB), 0);

        applyStimulus(1'b0, 1'b1);

        // Two frames of A, one frame of B, plus three extra cycles.
        for (int c = 0; c < 99; c++) begin
            @(negedge CLK);
            if (c < 96) begin
                lsCntA += int'(lsA);
                fsCntA += int'(fsA);
                lsCntB += int'(lsB);
                fsCntB += int'(fsB);
            end
            case (c)
                0: begin
                    checkOutput("lit.A.first_video_on", 32'(vidA), 1);
                    checkOutput("lit.A.first_tick", 32'(tickA), 1);
                    checkOutput("lit.B.first_tick", 32'(tickB), 0);
                end
                1:  checkOutput("lit.B.tick_c1", 32'(tickB), 1);
                2:  checkOutput("lit.B.video_on_c2", 32'(vidB), 0);
                3:  checkOutput("lit.B.video_on_c3", 32'(vidB), 1);
                5: begin
                    checkOutput("lit.A.hsync_x5", 32'(hsA), 1);
                    checkOutput("lit.A.video_on_x5", 32'(vidA), 0);
                end
                7:  checkOutput("lit.A.hsync_x7", 32'(hsA), 0);
                12: checkOutput("lit.B.hsync_c12", 32'(hsB), 0);
                13: checkOutput("lit.B.hsync_c13", 32'(hsB), 1);
                16: checkOutput("lit.B.hsync_c16", 32'(hsB), 1);
                17: checkOutput("lit.B.hsync_c17", 32'(hsB), 0);
                31: checkOutput("lit.A.vsync_y3", 32'(vsA), 0);
                36: checkOutput("lit.A.vsync_y4", 32'(vsA), 1);
                47: checkOutput("lit.A.frame_start_c47", 32'(fsA), 1);
                66: checkOutput("lit.B.vsync_c66", 32'(vsB), 1);
                67: checkOutput("lit.B.vsync_c67", 32'(vsB), 0);
                default: ;
            endcase
        end
        checkOutput("lit.A.line_starts", lsCntA, 12);
        checkOutput("lit.A.frame_starts", fsCntA, 2);
        checkOutput("lit.B.line_starts", lsCntB, 6);
        checkOutput("lit.B.frame_starts", fsCntB, 1);

        // Hold for 10 CLKs: A parked at X=3, B parked at X=1.
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            checkOutput("hold.A.pixel_X", 32'(xA), 3);
            checkOutput("hold.A.p_tick", 32'(tickA), 0);
            checkOutput("hold.A.video_on", 32'(vidA), 0);
            checkOutput("hold.A.sincro_horiz", 32'(hsA), 0);
            checkOutput("hold.B.pixel_X", 32'(xB), 1);
            checkOutput("hold.B.p_tick", 32'(tickB), 0);
        end

        // Resume, run a while, then pulse reset mid-frame.
        applyStimulus(1'b0, 1'b1);
        repeat (20) @(negedge CLK);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("rreset.A.pixel_X", 32'(xA), 0);
        checkOutput("rreset.A.pixel_Y", 32'(yA), 0);
        checkOutput("rreset.A.video_on", 32'(vidA), 1);
        checkOutput("rreset.B.pixel_X", 32'(xB), 0);
        checkOutput("rreset.B.pixel_Y", 32'(yB), 0);
        checkOutput("rreset.B.video_on", 32'(vidB), 0);
        checkOutput("rreset.B.sincro_horiz", 32'(hsB), 0);
        checkOutput("rreset.B.sincro_vert", 32'(vsB), 1);

        // A full frame of B after the reset, checked by the model.
        repeat (100) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sincronizador_vga_param.md
# sincronizador_vga_param

Parametrised VGA timing generator, successor to the fixed 640x480 sync block. Divides the system clock into a pixel tick and generates horizontal/vertical counters, sync pulses, a video-active flag, and line/frame start strobes. Every timing field, sync polarity and pixel divider ratio is a parameter. A run/hold enable and a configurable sync/blank delay line align the sync outputs with downstream pixel-fetch latency. The block sits between the system clock and the pixel-generation/RAM logic feeding the VGA connector.

## Interface
- DIV, 2: system clocks per pixel (>=1)
- H_VIS, 640: visible pixels per line
- H_FP, 16: horizontal front porch
- H_SYNC, 96: horizontal sync width
- H_BP, 48: horizontal back porch
- V_VIS, 480: visible lines
- V_FP, 10: vertical front porch
- V_SYNC, 2: vertical sync width
- V_BP, 33: vertical back porch
- H_POL, 0: hsync active level (0 = active low)
- V_POL, 0: vsync active level
- SYNC_DLY, 0: CLK register stages on sincro_horiz/sincro_vert/video_on (0..7)
- CW, 10: pixel_X/pixel_Y width; must hold H_TOTAL-1 and V_TOTAL-1
- CLK input 1: system clock, all logic rising-edge
- RESET input 1: synchronous, active-high
- ENABLE input 1: 1 = run, 0 = hold timing
- p_tick output 1: one-CLK pixel strobe
- pixel_X output CW: horizontal counter
- pixel_Y output CW: vertical counter
- video_on output 1: pixel inside visible area (delayed SYNC_DLY)
- sincro_horiz output 1: horizontal sync (delayed SYNC_DLY)
- sincro_vert output 1: vertical sync (delayed SYNC_DLY)
- line_start output 1: one-CLK strobe, counter wraps to pixel_X=0
- frame_start output 1: one-CLK strobe, counters wrap to (0,0)

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider div_cnt counts 0..DIV-1 while ENABLE=1; p_tick = ENABLE && div_cnt==DIV-1 (DIV=1: p_tick = ENABLE).
- On p_tick: pixel_X increments; at H_TOTAL-1 it wraps to 0 and pixel_Y increments; pixel_Y wraps at V_TOTAL-1 to 0.
- Undelayed decode: vis = X<H_VIS && Y<V_VIS; hs_act = X in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]; vs_act = Y in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1].
- sincro_horiz = hs_act ? H_POL : !H_POL; same for vertical with V_POL.
- ENABLE=0: div_cnt, pixel_X, pixel_Y hold; p_tick, line_start, frame_start = 0; decoded vis forced 0; syncs forced to inactive level before the delay line.
- line_start = p_tick && X==H_TOTAL-1; frame_start = line_start && Y==V_TOTAL-1.
- pixel_X/pixel_Y/strobes are not delayed; only video_on and syncs pass through SYNC_DLY stages.

## Timing
- RESET (sampled high at a CLK edge): div_cnt, pixel_X, pixel_Y = 0; all delay stages = video_on 0, syncs inactive.
- Reset-value outputs: p_tick 0, line_start 0, frame_start 0, video_on 0, sincro_horiz !H_POL, sincro_vert !V_POL.
- Reset mid-frame: next cycle restarts at (0,0), div_cnt 0; delay line flushed.
- With SYNC_DLY=0, outputs are combinational from the counter registers. The first cycle after reset release shows video_on=1 when ENABLE=1.
- With SYNC_DLY=N, video_on/syncs equal the undelayed decode of N CLK cycles earlier.
- First p_tick arrives DIV cycles after reset release (ENABLE held 1).
- Period: line = H_TOTAL*DIV CLKs; frame = H_TOTAL*V_TOTAL*DIV CLKs.
- ENABLE deassert/reassert resumes from the held div_cnt; no tick is lost or duplicated.

## Test plan
- Defaults, 20 ns CLK, ENABLE=1 -> p_tick every 2 CLKs. frame_start every 840000 CLKs (16.8 ms). line_start every 1600 CLKs.
- Defaults -> sincro_horiz low exactly for X=656..751 (192 CLKs). sincro_vert low for Y=490..491. video_on=1 only for X<640, Y<480.
- DIV=1, H 4/1/2/1, V 3/1/1/1, H_POL=V_POL=1 -> X cycles 0..7, Y cycles 0..5. hsync high at X=5,6. vsync high at Y=4. frame_start every 48 CLKs.
- SYNC_DLY=3, small config -> video_on/syncs are the SYNC_DLY=0 waveforms shifted exactly 3 CLKs. pixel_X is unshifted.
- ENABLE low 10 CLKs at X=100 -> X holds 100, no p_tick, video_on=0, syncs inactive. Resume yields the same sequence as uninterrupted.
- RESET pulse at (X=700,Y=300) -> next cycle X=Y=0, all outputs at reset values, delay line cleared. Full frame then matches the first test.
